// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults and receiver state encoding.
// Also referenced by the transmitter side.
package uart_pkg;

   localparam int UART_DATA_BITS  = 8;
   localparam int UART_OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } rx_state_t;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous pin.
// Reset value is a parameter so idle-high lines power up idle.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, oversampled by a baud-rate
// clock enable; reports each good byte or a framing error.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = UART_DATA_BITS,
   parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_tick,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);

   localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

   rx_state_t state;
   rx_state_t state_nxt;

   logic                 rx_s;
   logic [TW-1:0]        tick_cnt;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 tick_last;
   logic                 tick_mid;
   logic                 good;
   logic                 bad;

   sync_2ff #(
      .RST_VAL (1'b1)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx_in),
      .q   (rx_s)
   );

   assign tick_last = (tick_cnt == T_LAST);
   assign tick_mid  = (tick_cnt == T_MID);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else if (rx_tick)
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:
            if (!rx_s) state_nxt = START;
         START:
            if (tick_mid) state_nxt = rx_s ? IDLE : DATA;
         DATA:
            if (tick_last && bit_cnt == B_LAST)
               state_nxt = STOP;
         STOP:
            if (tick_last) state_nxt = rx_s ? IDLE : BREAK;
         BREAK:
            if (rx_s) state_nxt = IDLE;
         default:
            state_nxt = IDLE;
      endcase
   end

   // good/bad fire on the tick that samples mid-stop
   always_comb begin
      busy = 1'b1;
      good = 1'b0;
      bad  = 1'b0;
      unique case (1'b1)
         (state == IDLE):
            busy = 1'b0;
         (state == STOP): begin
            good = rx_tick && tick_last && rx_s;
            bad  = rx_tick && tick_last && !rx_s;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt   <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         data_valid <= good;
         frame_err  <= bad;
         if (good) data_out <= shreg;
         if (rx_tick) begin
            unique case (state)
               IDLE:
                  tick_cnt <= '0;
               START:
                  if (tick_mid) begin
                     tick_cnt <= '0;
                     bit_cnt  <= '0;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               DATA:
                  if (tick_last) begin
                     tick_cnt <= '0;
                     bit_cnt  <= bit_cnt + 1'b1;
                     shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               STOP:
                  if (tick_last)
                     tick_cnt <= '0;
                  else
                     tick_cnt <= tick_cnt + 1'b1;
               BREAK:
                  tick_cnt <= '0;
               default:
                  tick_cnt <= '0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame table plus break, glitch,
// mid-frame reset, back-to-back and slow-baud sequences.
module tb_uart_rx;

   logic       clk;
   logic       rst;
   logic       rx_tick;
   logic       rx_in;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_err;
   logic       busy;

   int errors;
   int checks;
   int nv;
   int ne;
   int nboth;
   int cyc;
   logic [7:0] vdat [8];
   int         vt   [8];

   typedef struct {
      logic [7:0] dat;
      logic       stop_hi;
      int         exp_nv;
      int         exp_ne;
      logic [7:0] exp_out;
   } vec_t;

   vec_t vecs [5];

   uart_rx dut (
      .clk        (clk),
      .rst        (rst),
      .rx_tick    (rx_tick),
      .rx_in      (rx_in),
      .data_out   (data_out),
      .data_valid (data_valid),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      rx_tick = 1'b0;
      forever begin
         repeat (3) @(negedge clk);
         rx_tick = 1'b1;
         @(negedge clk);
         rx_tick = 1'b0;
      end
   end

   always @(posedge clk) cyc = cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (data_valid) begin
            if (nv < 8) begin
               vdat[nv] = data_out;
               vt[nv]   = cyc;
            end
            nv = nv + 1;
         end
         if (frame_err) ne = ne + 1;
         if (data_valid && frame_err) nboth = nboth + 1;
      end
   end

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
      end
   endtask

   task automatic put_bit(input logic v, input int bt);
      rx_in = v;
      repeat (bt) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d,
                             input logic stop_hi,
                             input int bt);
      put_bit(1'b0, bt);
      for (int i = 0; i < 8; i++) put_bit(d[i], bt);
      put_bit(stop_hi, bt);
   endtask

   task automatic idle(input int nbits);
      put_bit(1'b1, nbits * 64);
   endtask

   task automatic clr;
      nv = 0;
      ne = 0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      nv     = 0;
      ne     = 0;
      nboth  = 0;
      cyc    = 0;
      rx_in  = 1'b1;
      rst    = 1'b1;

      vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
      vecs[1] = '{8'h3C, 1'b0, 0, 1, 8'hA5};
      vecs[2] = '{8'h5A, 1'b1, 1, 0, 8'h5A};
      vecs[3] = '{8'h00, 1'b1, 1, 0, 8'h00};
      vecs[4] = '{8'hFF, 1'b1, 1, 0, 8'hFF};

      repeat (3) @(negedge clk);
      check("rst_data",  32'(data_out),   32'h0);
      check("rst_valid", 32'(data_valid), 32'h0);
      check("rst_err",   32'(frame_err),  32'h0);
      check("rst_busy",  32'(busy),       32'h0);
      rst = 1'b0;
      idle(1);

      for (int i = 0; i < 5; i++) begin
         clr();
         send_frame(vecs[i].dat, vecs[i].stop_hi, 64);
         idle(2);
         check($sformatf("vec%0d_nv", i), 32'(nv),
               32'(vecs[i].exp_nv));
         check($sformatf("vec%0d_ne", i), 32'(ne),
               32'(vecs[i].exp_ne));
         check($sformatf("vec%0d_out", i), 32'(data_out),
               32'(vecs[i].exp_out));
         check($sformatf("vec%0d_busy", i), 32'(busy), 32'h0);
      end

      clr();
      send_frame(8'h00, 1'b1, 64);
      send_frame(8'hFF, 1'b1, 64);
      idle(2);
      check("b2b_nv",  32'(nv), 32'd2);
      check("b2b_d0",  32'(vdat[0]), 32'h00);
      check("b2b_d1",  32'(vdat[1]), 32'hFF);
      check("b2b_gap", 32'(vt[1] - vt[0]), 32'd640);
      check("b2b_ne",  32'(ne), 32'd0);

      clr();
      put_bit(1'b0, 12);
      put_bit(1'b1, 8);
      check("glitch_busy_hi", 32'(busy), 32'h1);
      put_bit(1'b1, 60);
      check("glitch_busy_lo", 32'(busy), 32'h0);
      check("glitch_nv", 32'(nv), 32'd0);
      check("glitch_ne", 32'(ne), 32'd0);

      clr();
      send_frame(8'h3C, 1'b0, 64);
      put_bit(1'b0, 3 * 64);
      check("brk_ne",   32'(ne), 32'd1);
      check("brk_nv",   32'(nv), 32'd0);
      check("brk_data", 32'(data_out), 32'hFF);
      check("brk_busy", 32'(busy), 32'h1);
      idle(2);
      check("brk_exit", 32'(busy), 32'h0);
      clr();
      send_frame(8'h5A, 1'b1, 64);
      idle(2);
      check("brk_next_nv", 32'(nv), 32'd1);
      check("brk_next_d",  32'(data_out), 32'h5A);

      clr();
      put_bit(1'b0, 64);
      put_bit(1'b1, 64);
      put_bit(1'b0, 64);
      put_bit(1'b0, 64);
      put_bit(1'b0, 64);
      put_bit(1'b0, 32);
      rst = 1'b1;
      #1;
      check("mrst_data",  32'(data_out),   32'h0);
      check("mrst_valid", 32'(data_valid), 32'h0);
      check("mrst_err",   32'(frame_err),  32'h0);
      check("mrst_busy",  32'(busy),       32'h0);
      repeat (10) @(negedge clk);
      rx_in = 1'b1;
      rst   = 1'b0;
      idle(10);
      check("mrst_nv", 32'(nv), 32'd0);
      check("mrst_ne", 32'(ne), 32'd0);
      send_frame(8'h81, 1'b1, 64);
      idle(2);
      check("mrst_next_nv", 32'(nv), 32'd1);
      check("mrst_next_d",  32'(data_out), 32'h81);

      clr();
      send_frame(8'h55, 1'b1, 66);
      idle(2);
      check("slow_nv", 32'(nv), 32'd1);
      check("slow_d",  32'(data_out), 32'h55);
      check("slow_ne", 32'(ne), 32'd0);

      check("never_both", 32'(nboth), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
